// File: rtl/pipe_pkg.sv
// Shared definitions for the parametrised inter-stage pipeline registers:
// occupancy state, counter width and the per-stage control-bundle widths.
package pipe_pkg;

  localparam int CNT_W = 2;

  // Control widths of the classic five-stage datapath boundaries
  localparam int IFID_CTRL_W  = 1;
  localparam int IDEX_CTRL_W  = 9;
  localparam int EXMEM_CTRL_W = 5;
  localparam int MEMWB_CTRL_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] state_count(input state_t s);
    logic [CNT_W-1:0] cnt;
    case (s)
      ONE:     cnt = 2'd1;
      FULL:    cnt = 2'd2;
      default: cnt = 2'd0;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One payload+control slot of the stage buffer; the control part can be
// cleared on its own so a flushed slot never carries live control bits.
module pipe_entry_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic              clr_ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (clr_ctrl_i) begin
      ctrl_d = '0;
    end else if (load_i) begin
      data_d = data_i;
      ctrl_d = ctrl_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q <= '0;
      ctrl_q <= '0;
    end else begin
      data_q <= data_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign data_o = data_q;
  assign ctrl_o = ctrl_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage register with a two-entry skid buffer, a
// synchronous flush and a global start gate that freezes all state.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W               = 64,
  parameter int CTRL_W               = 4,
  parameter bit CLEAR_CTRL_ON_BUBBLE = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [CNT_W-1:0]  count_o
);

  state_t state_q, state_d;

  logic in_fire, out_fire, flush_act;
  logic main_load, skid_load, main_from_skid;

  logic [DATA_W-1:0] main_data, skid_data, main_src_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_src_ctrl;

  // Ready depends only on registered state, never on out_ready_i
  assign in_ready_o  = (state_q != FULL) && start_i;
  assign out_valid_o = (state_q != EMPTY) && start_i;
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_fire    = out_valid_o && out_ready_i;
  assign flush_act   = start_i && flush_i;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush_act) begin
      state_d = EMPTY;
    end else if (start_i) begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d        = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign main_src_data = main_from_skid ? skid_data : in_data_i;
  assign main_src_ctrl = main_from_skid ? skid_ctrl : in_ctrl_i;

  pipe_entry_reg #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_main (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (main_load),
    .clr_ctrl_i (flush_act),
    .data_i     (main_src_data),
    .ctrl_i     (main_src_ctrl),
    .data_o     (main_data),
    .ctrl_o     (main_ctrl)
  );

  pipe_entry_reg #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (skid_load),
    .clr_ctrl_i (flush_act),
    .data_i     (in_data_i),
    .ctrl_i     (in_ctrl_i),
    .data_o     (skid_data),
    .ctrl_o     (skid_ctrl)
  );

  assign out_data_o = main_data;
  assign count_o    = state_count(state_q);

  // Masking keeps a bubble from ever presenting live control (e.g. RegWrite)
  generate
    if (CLEAR_CTRL_ON_BUBBLE) begin : g_ctrl_mask
      assign out_ctrl_o = out_valid_o ? main_ctrl : '0;
    end else begin : g_ctrl_hold
      assign out_ctrl_o = main_ctrl;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed and random checks of pipe_stage_buf against a queue-based model,
// run on a masking instance and a holding instance fed identical inputs.
module tb_pipe_stage_buf;

  localparam int DATA_W = 64;
  localparam int CTRL_W = 4;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              start_i = 1'b0;
  logic              flush_i = 1'b0;
  logic              in_valid_i = 1'b0;
  logic              out_ready_i = 1'b0;
  logic [DATA_W-1:0] in_data_i = '0;
  logic [CTRL_W-1:0] in_ctrl_i = '0;

  logic              in_ready_o, out_valid_o;
  logic [DATA_W-1:0] out_data_o;
  logic [CTRL_W-1:0] out_ctrl_o;
  logic [1:0]        count_o;

  logic              h_in_ready_o, h_out_valid_o;
  logic [DATA_W-1:0] h_out_data_o;
  logic [CTRL_W-1:0] h_out_ctrl_o;
  logic [1:0]        h_count_o;

  entry_t modelQ[$];
  entry_t lastHead = '0;
  int     checks = 0;
  int     errors = 0;

  always #5 clk_i = ~clk_i;

  pipe_stage_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_CTRL_ON_BUBBLE(1'b1)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .in_ctrl_i(in_ctrl_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_ctrl_o(out_ctrl_o), .count_o(count_o)
  );

  pipe_stage_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_CTRL_ON_BUBBLE(1'b0)) dut_hold (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(h_in_ready_o), .in_data_i(in_data_i),
    .in_ctrl_i(in_ctrl_i), .out_valid_o(h_out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(h_out_data_o), .out_ctrl_o(h_out_ctrl_o), .count_o(h_count_o)
  );

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected values come from the entry queue: head visible, bubble shows last head
  task automatic checkOutput();
    bit expValid, expReady;
    expValid = start_i && (modelQ.size() > 0);
    expReady = start_i && (modelQ.size() < 2);
    checkVal("in_ready",   64'(in_ready_o),  64'(expReady));
    checkVal("out_valid",  64'(out_valid_o), 64'(expValid));
    checkVal("count",      64'(count_o),     64'(modelQ.size()));
    checkVal("out_data",   64'(out_data_o),  64'(lastHead.data));
    checkVal("out_ctrl",   64'(out_ctrl_o),  expValid ? 64'(lastHead.ctrl) : 64'd0);
    checkVal("hold_valid", 64'(h_out_valid_o), 64'(expValid));
    checkVal("hold_count", 64'(h_count_o),   64'(modelQ.size()));
    checkVal("hold_data",  64'(h_out_data_o), 64'(lastHead.data));
    checkVal("hold_ctrl",  64'(h_out_ctrl_o), 64'(lastHead.ctrl));
  endtask

  task automatic applyStimulus(input bit st, input bit fl, input bit iv,
                               input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                               input bit ordy);
    bit inFire, outFire;
    entry_t e;
    @(negedge clk_i);
    start_i     = st;
    flush_i     = fl;
    in_valid_i  = iv;
    in_data_i   = d;
    in_ctrl_i   = c;
    out_ready_i = ordy;
    #1;
    checkOutput();
    inFire  = st && iv && (modelQ.size() < 2);
    outFire = st && ordy && (modelQ.size() > 0);
    @(posedge clk_i);
    if (st) begin
      if (fl) begin
        modelQ.delete();
        lastHead.ctrl = '0;
      end else begin
        if (outFire) void'(modelQ.pop_front());
        if (inFire) begin
          e.data = d;
          e.ctrl = c;
          modelQ.push_back(e);
        end
      end
      if (modelQ.size() > 0) lastHead = modelQ[0];
    end
  endtask

  task automatic modelReset();
    modelQ.delete();
    lastHead = '0;
  endtask

  initial begin
    $display("[TB] reset");
    start_i = 1'b1;
    #12;
    checkOutput();
    #10;
    rst_n_i = 1'b1;
    #1;
    checkOutput();

    $display("[TB] streaming");
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1, 0, 1, 64'(i), 4'(i), 1);
    end
    applyStimulus(1, 0, 0, '0, '0, 1);

    $display("[TB] stall and skid");
    applyStimulus(1, 0, 1, 64'hA, 4'h1, 1);
    applyStimulus(1, 0, 1, 64'hB, 4'h2, 0);
    applyStimulus(1, 0, 1, 64'hC, 4'h3, 0);
    applyStimulus(1, 0, 1, 64'hC, 4'h3, 0);
    applyStimulus(1, 0, 1, 64'hC, 4'h3, 1);
    applyStimulus(1, 0, 1, 64'hC, 4'h3, 1);
    applyStimulus(1, 0, 0, '0, '0, 1);
    applyStimulus(1, 0, 0, '0, '0, 1);

    $display("[TB] flush");
    applyStimulus(1, 0, 1, 64'hD1, 4'hF, 1);
    applyStimulus(1, 0, 1, 64'hD2, 4'hE, 0);
    applyStimulus(1, 1, 1, 64'hD3, 4'hD, 0);
    applyStimulus(1, 0, 0, '0, '0, 1);
    applyStimulus(1, 0, 1, 64'hE1, 4'h7, 0);
    applyStimulus(1, 1, 1, 64'hE2, 4'h6, 0);
    applyStimulus(1, 0, 0, '0, '0, 1);

    $display("[TB] start gating");
    applyStimulus(1, 0, 1, 64'hABCD, 4'h5, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1'($urandom), 1'($urandom), {$urandom, $urandom}, 4'($urandom), 1'($urandom));
    end
    applyStimulus(1, 0, 0, '0, '0, 0);
    applyStimulus(1, 0, 0, '0, '0, 1);

    $display("[TB] bubble masking");
    applyStimulus(1, 0, 1, 64'h5A5A, 4'b1011, 1);
    applyStimulus(1, 0, 0, '0, '0, 1);
    applyStimulus(1, 0, 0, '0, '0, 1);

    $display("[TB] reset mid-stream");
    applyStimulus(1, 0, 1, 64'h111, 4'h9, 0);
    applyStimulus(1, 0, 1, 64'h222, 4'hA, 0);
    applyStimulus(1, 0, 0, '0, '0, 0);
    #2;
    rst_n_i = 1'b0;
    modelReset();
    #1;
    checkOutput();
    #1;
    rst_n_i = 1'b1;
    #1;
    checkOutput();

    $display("[TB] random");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                    1'($urandom), {$urandom, $urandom}, 4'($urandom), 1'($urandom));
    end
    @(negedge clk_i);
    #1;
    checkOutput();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised pipeline-stage register, successor to the fixed-field inter-stage registers (IF/ID … MEM/WB). It carries a DATA_W payload plus a CTRL_W control bundle between two pipeline stages using valid/ready handshaking. A 2-entry skid buffer lets in_ready_o be registered without losing throughput. It also adds a synchronous flush and global start gating. One instance replaces each hand-written stage register.

Parameters:
DATA_W, 64, payload width (ALU result, read data, addresses, etc.), must be ≥1
CTRL_W, 4, control-bit width (RegWrite, MemtoReg, …), must be ≥1
CLEAR_CTRL_ON_BUBBLE, 1, when 1 out_ctrl_o reads 0 whenever out_valid_o=0

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  global run enable; low = freeze all state
flush_i  in  1  synchronous flush; discards all held and incoming entries
in_valid_i  in  1  upstream entry valid
in_ready_o  out  1  stage can accept an entry (registered part AND start_i)
in_data_i  in  DATA_W  upstream payload
in_ctrl_i  in  CTRL_W  upstream control bundle
out_valid_o  out  1  entry valid toward downstream
out_ready_i  in  1  downstream accepts
out_data_o  out  DATA_W  head payload
out_ctrl_o  out  CTRL_W  head control bundle (masked per CLEAR_CTRL_ON_BUBBLE)
count_o  out  2  occupancy, 0..2

Behaviour:
- Reset is asynchronous and active-low. Asserting rst_n_i=0 gives state EMPTY, count_o=0, out_valid_o=0, and clears the main/skid data and ctrl registers to 0. The first cycle after release has in_ready_o=start_i.
- in_fire = in_valid_i & in_ready_o. out_fire = out_valid_o & out_ready_i.
- in_ready_o = (state != FULL) & start_i. The state term is registered, so there is no combinational path from out_ready_i.
- out_valid_o = (state != EMPTY) & start_i.
- out_data_o and out_ctrl_o always come from the main register.
- start_i=0: all registers hold and no fire can occur. in_data_i and in_ctrl_i are ignored.
- Priority: reset > flush_i > normal transfer.
- flush_i=1 with start_i=1:
  - next state is EMPTY and count goes to 0;
  - a coincident in_fire is discarded;
  - a coincident out_fire is still counted as consumed by downstream;
  - main and skid ctrl registers are cleared to 0; data registers keep their values.
- flush_i is ignored while start_i=0.
- State machine, one transition per clock while start_i=1 and flush_i=0:
  - EMPTY: in_fire → ONE, main<=in.
  - ONE, in_fire & out_fire → ONE, main<=in.
  - ONE, in_fire & !out_fire → FULL, skid<=in.
  - ONE, !in_fire & out_fire → EMPTY.
  - ONE, no fire → ONE, hold.
  - FULL (in_ready_o=0): out_fire → ONE, main<=skid. No fire → FULL, hold.
- Latency: an entry accepted at edge N is visible at out_* after edge N. With out_ready_i held 1, throughput is 1 entry/cycle and the state stays in ONE.
- Order is strict FIFO. No entry is duplicated or dropped, except by flush.
- Downstream stall: when out_ready_i drops, at most one further entry is absorbed (skid). After that, in_ready_o falls on the next edge.
- While out_valid_o=0, out_data_o holds its last value. out_ctrl_o is 0 if CLEAR_CTRL_ON_BUBBLE=1, else it holds its last value. This guarantees a bubble never asserts RegWrite.
- count_o always equals the number of valid entries: EMPTY=0, ONE=1, FULL=2.

Decomposition:
- Shared package pipe_pkg holds:
  - the state typedef, enum {EMPTY, ONE, FULL}, 2-bit encoding;
  - a localparam for the occupancy width;
  - the per-stage CTRL_W constants (IFID_CTRL_W, IDEX_CTRL_W, EXMEM_CTRL_W, MEMWB_CTRL_W).
- One natural sub-module, pipe_entry_reg: a DATA_W+CTRL_W register with load enable, async active-low clear and ctrl-only synchronous clear. It is instantiated twice, as main and skid.
- Control FSM and output masking live in the top.

Test Plan:
- Reset mid-stream: with state FULL, pull rst_n_i low between clock edges → out_valid_o=0, count_o=0 and out_ctrl_o=0 immediately, without waiting for a clock edge. After release with start_i=1 → in_ready_o=1.
- Streaming: out_ready_i=1, push data 0x1..0x8 on consecutive cycles → the same sequence appears on out_data_o one cycle later, and count_o stays 1.
- Stall/skid:
  - Push A,B,C back-to-back and drop out_ready_i as A is presented.
  - Expect B in skid, count_o=2, in_ready_o=0, and C held upstream.
  - Raise out_ready_i → A, B, C emerge in order with none lost or duplicated.
- Flush in FULL: in_valid_i=1 at the same time as flush_i → next cycle count_o=0, out_valid_o=0 and out_ctrl_o=0. The flushed input never appears.
- start_i gating: state ONE with data 0xABCD, start_i=0 for 5 cycles while toggling in_valid_i/out_ready_i/flush_i → no change to any register. in_ready_o=0 and out_valid_o=0 throughout. After start_i=1, 0xABCD is presented.
- Bubble masking: CLEAR_CTRL_ON_BUBBLE=1, drain to EMPTY after ctrl=4'b1011 → out_ctrl_o=0. Repeat with the parameter at 0 → out_ctrl_o holds 4'b1011 while out_valid_o=0.
